// File: rtl/rtc_bus_if.sv
// rtc_bus_if: single-request engine for the multiplexed RTC bus.
// A request is accepted over valid/ready and then played out as
// address phase, CS_n-high gap, data phase and recovery. All outputs are
// registered and decoded from the next state, so they change on the edge
// that enters a state.
module rtc_bus_if #(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_PW  = 5,
  parameter int unsigned T_HD  = 2,
  parameter int unsigned T_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       busy_o,
  output logic       rtc_cs_n_o,
  output logic       rtc_wr_n_o,
  output logic       rtc_rd_n_o,
  output logic       rtc_ad_o,
  output logic [7:0] bus_out_o,
  output logic       bus_oe_o,
  input  logic [7:0] bus_in_i
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    A_SU  = 4'd1,
    A_STB = 4'd2,
    A_HD  = 4'd3,
    GAP   = 4'd4,
    D_SU  = 4'd5,
    D_STB = 4'd6,
    D_HD  = 4'd7,
    REC   = 4'd8
  } state_t;

  localparam logic [3:0] LD_SU  = 4'(T_SU - 1);
  localparam logic [3:0] LD_PW  = 4'(T_PW - 1);
  localparam logic [3:0] LD_HD  = 4'(T_HD - 1);
  localparam logic [3:0] LD_GAP = 4'(T_GAP - 1);

  // Dwell counter preload for the state being entered.
  function automatic logic [3:0] load_f(input state_t s);
    logic [3:0] v;
    case (s)
      A_SU, D_SU:   v = LD_SU;
      A_STB, D_STB: v = LD_PW;
      A_HD, D_HD:   v = LD_HD;
      GAP, REC:     v = LD_GAP;
      default:      v = 4'd0;
    endcase
    return v;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       write_q, write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic       ad_q, ad_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;

  logic       cnt_zero_s;

  assign cnt_zero_s = (cnt_q == 4'd0);

  // Next-state, dwell counter and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = A_SU;
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
        end else begin
          state_d = IDLE;
        end
      end
      A_SU:    state_d = cnt_zero_s ? A_STB : A_SU;
      A_STB:   state_d = cnt_zero_s ? A_HD  : A_STB;
      A_HD:    state_d = cnt_zero_s ? GAP   : A_HD;
      GAP:     state_d = cnt_zero_s ? D_SU  : GAP;
      D_SU:    state_d = cnt_zero_s ? D_STB : D_SU;
      D_STB:   state_d = cnt_zero_s ? D_HD  : D_STB;
      D_HD:    state_d = cnt_zero_s ? REC   : D_HD;
      REC:     state_d = cnt_zero_s ? IDLE  : REC;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = load_f(state_d);
    end else if (!cnt_zero_s) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the next state; response and read capture from the current one.
  always_comb begin
    cs_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    rd_n_d      = 1'b1;
    ad_d        = 1'b0;
    oe_d        = 1'b0;
    dout_d      = 8'h00;
    ready_d     = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    case (state_d)
      A_SU, A_HD: begin
        cs_n_d = 1'b0;
        oe_d   = 1'b1;
        dout_d = addr_d;
      end
      A_STB: begin
        cs_n_d = 1'b0;
        oe_d   = 1'b1;
        dout_d = addr_d;
        wr_n_d = 1'b0;
      end
      GAP: begin
        ad_d = 1'b1;
      end
      D_SU, D_HD: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b1;
        if (write_d) begin
          oe_d   = 1'b1;
          dout_d = wdata_d;
        end else begin
          oe_d = 1'b0;
        end
      end
      D_STB: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b1;
        if (write_d) begin
          oe_d   = 1'b1;
          dout_d = wdata_d;
          wr_n_d = 1'b0;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
    if ((state_q == REC) && cnt_zero_s) begin
      rsp_valid_d = 1'b1;
    end else begin
      rsp_valid_d = 1'b0;
    end
    // Pad is sampled at the edge that ends the read strobe.
    if ((state_q == D_STB) && cnt_zero_s && !write_q) begin
      rdata_d = bus_in_i;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Sequencer state, dwell counter and latched request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Registered bus strobes, handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      ad_q        <= 1'b0;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      ad_q        <= ad_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rtc_cs_n_o  = cs_n_q;
  assign rtc_wr_n_o  = wr_n_q;
  assign rtc_rd_n_o  = rd_n_q;
  assign rtc_ad_o    = ad_q;
  assign bus_out_o   = dout_q;
  assign bus_oe_o    = oe_q;

endmodule

// File: tb/tb_rtc_bus_if.sv
// tb_rtc_bus_if: drives two instances (default timing and all-ones timing)
// and compares every bus cycle against a waveform computed from the
// phase durations.
module tb_rtc_bus_if;

  logic       clk;
  logic       reset;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_write [2];
  logic [7:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       busy      [2];
  logic       cs_n      [2];
  logic       wr_n      [2];
  logic       rd_n      [2];
  logic       ad        [2];
  logic [7:0] bus_out   [2];
  logic       bus_oe    [2];
  logic [7:0] bus_in    [2];

  int errors = 0;
  int checks = 0;
  int rsp_cnt = 0;
  int su [2] = '{2, 1};
  int pw [2] = '{5, 1};
  int hd [2] = '{2, 1};
  int gp [2] = '{4, 1};
  logic [7:0] last_rd [2] = '{8'h00, 8'h00};

  rtc_bus_if dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .busy_o(busy[0]),
    .rtc_cs_n_o(cs_n[0]), .rtc_wr_n_o(wr_n[0]), .rtc_rd_n_o(rd_n[0]), .rtc_ad_o(ad[0]),
    .bus_out_o(bus_out[0]), .bus_oe_o(bus_oe[0]), .bus_in_i(bus_in[0])
  );

  rtc_bus_if #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .busy_o(busy[1]),
    .rtc_cs_n_o(cs_n[1]), .rtc_wr_n_o(wr_n[1]), .rtc_rd_n_o(rd_n[1]), .rtc_ad_o(ad[1]),
    .bus_out_o(bus_out[1]), .bus_oe_o(bus_oe[1]), .bus_in_i(bus_in[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       ad;
    logic       oe;
    logic [7:0] dout;
  } bus_t;

  // Expected pins k cycles after acceptance, from the phase lengths alone.
  function automatic bus_t exp_bus(input int k, input int s, input int p, input int h,
                                   input int g, input bit wr,
                                   input logic [7:0] addr, input logic [7:0] wdata);
    bus_t e;
    int a;
    int j;
    a = s + p + h;
    e.cs_n = 1'b1; e.wr_n = 1'b1; e.rd_n = 1'b1; e.ad = 1'b0; e.oe = 1'b0; e.dout = 8'h00;
    if (k < a) begin
      e.cs_n = 1'b0; e.oe = 1'b1; e.dout = addr;
      if (k >= s && k < s + p) e.wr_n = 1'b0;
    end else if (k < a + g) begin
      e.ad = 1'b1;
    end else if (k < 2 * a + g) begin
      j = k - a - g;
      e.cs_n = 1'b0; e.ad = 1'b1; e.oe = wr; e.dout = wr ? wdata : 8'h00;
      if (j >= s && j < s + p) begin
        if (wr) e.wr_n = 1'b0;
        else    e.rd_n = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus invariants on both instances, every cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("inv_wr_rd_%0d", d), {31'd0, !(wr_n[d] === 1'b0 && rd_n[d] === 1'b0)}, 32'd1);
      chk($sformatf("inv_cs_strobe_%0d", d),
          {31'd0, !(cs_n[d] === 1'b1 && (wr_n[d] === 1'b0 || rd_n[d] === 1'b0))}, 32'd1);
      chk($sformatf("inv_rd_oe_%0d", d), {31'd0, !(rd_n[d] === 1'b0 && bus_oe[d] === 1'b1)}, 32'd1);
    end
    if (rsp_valid[0] === 1'b1) rsp_cnt++;
  end

  // One complete transaction on instance d; caller sits #1 after an edge in an idle cycle.
  task automatic txn(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic [7:0] rv, input bit chain, input logic [7:0] busy_addr);
    int   len;
    bus_t e;
    len = 2 * (su[d] + pw[d] + hd[d]) + 2 * gp[d];
    req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata; req_valid[d] = 1'b1;
    @(posedge clk); #1;
    // Anything presented while busy must be ignored.
    req_addr[d] = busy_addr; req_wdata[d] = ~wdata; req_write[d] = ~wr;
    if (!chain) req_valid[d] = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      e = exp_bus(k, su[d], pw[d], hd[d], gp[d], wr, addr, wdata);
      bus_in[d] = (e.rd_n == 1'b0) ? rv : 8'hFF;
      chk($sformatf("cs_n d%0d k%0d", d, k), {31'd0, cs_n[d]}, {31'd0, e.cs_n});
      chk($sformatf("wr_n d%0d k%0d", d, k), {31'd0, wr_n[d]}, {31'd0, e.wr_n});
      chk($sformatf("rd_n d%0d k%0d", d, k), {31'd0, rd_n[d]}, {31'd0, e.rd_n});
      chk($sformatf("ad d%0d k%0d", d, k), {31'd0, ad[d]}, {31'd0, e.ad});
      chk($sformatf("oe d%0d k%0d", d, k), {31'd0, bus_oe[d]}, {31'd0, e.oe});
      if (e.oe) chk($sformatf("bus_out d%0d k%0d", d, k), {24'd0, bus_out[d]}, {24'd0, e.dout});
      chk($sformatf("rsp_valid d%0d k%0d", d, k), {31'd0, rsp_valid[d]}, {31'd0, k == len});
      chk($sformatf("req_ready d%0d k%0d", d, k), {31'd0, req_ready[d]}, {31'd0, k == len});
      chk($sformatf("busy d%0d k%0d", d, k), {31'd0, busy[d]}, {31'd0, k != len});
    end
    if (!wr) last_rd[d] = rv;
    chk($sformatf("rsp_rdata d%0d", d), {24'd0, rsp_rdata[d]}, {24'd0, last_rd[d]});
    if (!chain) begin
      @(posedge clk); #1;
      chk($sformatf("rsp_pulse_end d%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
      chk($sformatf("idle_cs_n d%0d", d), {31'd0, cs_n[d]}, 32'd1);
      chk($sformatf("idle_ready d%0d", d), {31'd0, req_ready[d]}, 32'd1);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s ready d%0d", tag, d), {31'd0, req_ready[d]}, 32'd1);
      chk($sformatf("%s busy d%0d", tag, d), {31'd0, busy[d]}, 32'd0);
      chk($sformatf("%s rsp_valid d%0d", tag, d), {31'd0, rsp_valid[d]}, 32'd0);
      chk($sformatf("%s rdata d%0d", tag, d), {24'd0, rsp_rdata[d]}, 32'd0);
      chk($sformatf("%s strobes d%0d", tag, d), {29'd0, cs_n[d], wr_n[d], rd_n[d]}, 32'd7);
      chk($sformatf("%s ad d%0d", tag, d), {31'd0, ad[d]}, 32'd0);
      chk($sformatf("%s bus_out d%0d", tag, d), {24'd0, bus_out[d]}, 32'd0);
      chk($sformatf("%s oe d%0d", tag, d), {31'd0, bus_oe[d]}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rc;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 8'h00;
      req_wdata[d] = 8'h00; bus_in[d] = 8'hFF;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Directed write and read with default timing.
    txn(0, 1'b1, 8'h23, 8'h45, 8'h00, 1'b0, 8'h00);
    txn(0, 1'b0, 8'h21, 8'h00, 8'h59, 1'b0, 8'h00);

    // req_valid held across two requests.
    rc = rsp_cnt;
    txn(0, 1'b1, 8'h10, 8'h77, 8'h00, 1'b1, 8'hEE);
    txn(0, 1'b0, 8'h11, 8'h00, 8'h3C, 1'b0, 8'h00);
    chk("two_rsp_pulses", rsp_cnt - rc, 32'd2);

    // Reset in the middle of a write data strobe.
    req_write[0] = 1'b1; req_addr[0] = 8'h42; req_wdata[0] = 8'h99; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("pre_abort_wr_n", {31'd0, wr_n[0]}, 32'd0);
    #2 reset = 1'b1;
    rc = rsp_cnt;
    @(posedge clk); #1;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    chk_reset_state("abort");
    @(negedge clk) reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("no_rsp_after_abort", rsp_cnt - rc, 32'd0);
    txn(0, 1'b0, 8'h05, 8'h00, 8'hC3, 1'b0, 8'h00);

    // Minimal timing instance.
    txn(1, 1'b0, 8'h30, 8'h00, 8'hA5, 1'b0, 8'h00);
    txn(1, 1'b1, 8'h31, 8'h5A, 8'h00, 1'b0, 8'h00);

    // Random traffic on both instances.
    for (int i = 0; i < 6; i++) begin
      txn(i % 2, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
